// File: rtl/seq_match_pkg.sv
// rtl/seq_match_pkg.sv - shared types, bounds and parameter check for seq_match_fsm
package seq_match_pkg;

  typedef enum logic {NON_OVERLAP = 1'b0, OVERLAP = 1'b1} match_mode_t;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

  function automatic bit params_ok(input int pat_w, input int cnt_w);
    return (pat_w >= PAT_W_MIN) && (pat_w <= PAT_W_MAX) &&
           (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
  endfunction

endpackage

// File: rtl/seq_match_fsm_sat_counter.sv
// rtl/seq_match_fsm_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_match_fsm.sv
// rtl/seq_match_fsm.sv - serial pattern detector with Mealy match strobe
// SEQ_MATCH_COUNT_EN adds the saturating match counter; otherwise count is tied to 0.
module seq_match_fsm
  import seq_match_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             clear,
  output logic             out,
  output logic             match_q,
  output logic [CNT_W-1:0] count
);

  if (!params_ok(PAT_W, CNT_W)) begin : g_bad_params
    $error("seq_match_fsm: PAT_W or CNT_W out of range");
  end

  localparam int              FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist, hist_nxt;
  logic [FILL_W-1:0] fill, fill_nxt;
  logic [PAT_W-1:0]  window;
  logic              match;

  // window holds the candidate PAT_W bits with the incoming bit as LSB
  assign window = {hist, in};

  always_comb begin
    match    = in_valid & ~clear & (fill == FILL_MAX) & (window == PATTERN);
    hist_nxt = hist;
    fill_nxt = fill;
    if (clear) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (in_valid) begin
      hist_nxt = window[PAT_W-2:0];
      // non-overlap: matched bits must not seed the next match
      if (match && (match_mode_t'(overlap) == NON_OVERLAP)) begin
        fill_nxt = '0;
      end else if (fill != FILL_MAX) begin
        fill_nxt = fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist    <= '0;
      fill    <= '0;
      match_q <= 1'b0;
    end else begin
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      match_q <= match;
    end
  end

  assign out = match;

`ifdef SEQ_MATCH_COUNT_EN
  sat_counter #(.W(CNT_W)) u_count (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .inc     (match),
    .q       (count)
  );
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_seq_match_fsm.sv
// tb/tb_seq_match_fsm.sv - scoreboard bench for seq_match_fsm
module tb_seq_match_fsm;

`ifdef SEQ_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, in_valid, in_bit, overlap, clear;
  logic       out_bit, match_q;
  logic [7:0] count;

  logic       in_valid2, in_bit2, overlap2, clear2;
  logic       out2, match_q2;
  logic [1:0] count2;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_match_fsm #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in(in_bit),
    .overlap(overlap), .clear(clear), .out(out_bit), .match_q(match_q),
    .count(count)
  );

  seq_match_fsm #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in(in_bit2),
    .overlap(overlap2), .clear(clear2), .out(out2), .match_q(match_q2),
    .count(count2)
  );

  function automatic logic [7:0] exp_count(input int n);
    return CNT_EN ? 8'(n) : 8'd0;
  endfunction

  task automatic drive(input logic r, input logic v, input logic b,
                       input logic c, input logic e);
    @(posedge clk);
    #1;
    reset_n  = r;
    in_valid = v;
    in_bit   = b;
    clear    = c;
    exp_q.push_back(e);
  endtask

  task automatic send_stream(input logic [15:0] bits, input logic [15:0] exps,
                             input int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, 1'b1, bits[i], 1'b0, exps[i]);
  endtask

  task automatic run_monitor();
    logic e;
    logic prev_e;
    prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (out_bit !== e) $display("FAIL out: got %b want %b at %0t", out_bit, e, $time);
        else pass_cnt++;
        total_cnt++;
        if (match_q !== prev_e) $display("FAIL match_q: got %b want %b at %0t", match_q, prev_e, $time);
        else pass_cnt++;
        prev_e = e;
      end else begin
        prev_e = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; in_bit = 1'b1; clear = 1'b0; overlap = 1'b1;
    in_valid2 = 1'b0; in_bit2 = 1'b0; clear2 = 1'b0; overlap2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (out_bit !== 1'b0) $display("FAIL reset_out: got %b want 0", out_bit); else pass_cnt++;
    total_cnt++;
    if (match_q !== 1'b0) $display("FAIL reset_match_q: got %b want 0", match_q); else pass_cnt++;
    total_cnt++;
    if (count !== 8'd0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
  endtask

  task automatic test_overlap();
    overlap = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_stream(16'b1011011, 16'b0001001, 7);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    total_cnt++;
    if (count !== exp_count(2)) $display("FAIL overlap_count: got %0d want %0d", count, exp_count(2));
    else pass_cnt++;
  endtask

  task automatic test_non_overlap();
    overlap = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_stream(16'b1011011, 16'b0001000, 7);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    total_cnt++;
    if (count !== exp_count(1)) $display("FAIL nonoverlap_count: got %0d want %0d", count, exp_count(1));
    else pass_cnt++;
  endtask

  task automatic test_valid_gaps();
    overlap = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    total_cnt++;
    if (count !== exp_count(1)) $display("FAIL gaps_count: got %0d want %0d", count, exp_count(1));
    else pass_cnt++;
  endtask

  task automatic test_clear_priority();
    overlap = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_stream(16'b101, 16'b000, 3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_stream(16'b011, 16'b000, 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    total_cnt++;
    if (count !== 8'd0) $display("FAIL clear_count: got %0d want 0", count); else pass_cnt++;
    send_stream(16'b1011, 16'b0001, 4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    total_cnt++;
    if (count !== exp_count(1)) $display("FAIL clear_rematch_count: got %0d want %0d", count, exp_count(1));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_pattern();
    overlap = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_stream(16'b101, 16'b000, 3);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_stream(16'b1011, 16'b0001, 4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    total_cnt++;
    if (count !== exp_count(1)) $display("FAIL rst_mid_count: got %0d want %0d", count, exp_count(1));
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    want = CNT_EN ? 2'd3 : 2'd0;
    overlap2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      in_valid2 = 1'b1;
      in_bit2   = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (out2 !== (i >= 3)) $display("FAIL sat_out[%0d]: got %b want %b", i, out2, (i >= 3));
      else pass_cnt++;
    end
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    #1;
    total_cnt++;
    if (count2 !== want) $display("FAIL sat_count: got %0d want %0d", count2, want); else pass_cnt++;
    total_cnt++;
    if (match_q2 !== 1'b1) $display("FAIL sat_match_q: got %b want 1", match_q2); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    fork
      run_monitor();
    join_none
    test_overlap();
    test_non_overlap();
    test_valid_gaps();
    test_clear_priority();
    test_reset_mid_pattern();
    repeat (3) @(posedge clk);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else pass_cnt++;
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
